// File: rtl/fpu_sp_issuer.sv
// Single-outstanding command initiator for the SP FPU: takes a tagged request,
// pulses the FPU inputs, waits for rdy (or times out) and returns a tagged response.
module fpu_sp_issuer #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [3:0]       fpu_cmd,
  output logic [63:0]      fpu_din1,
  output logic [63:0]      fpu_din2,
  output logic             fpu_dval,
  input  logic [63:0]      fpu_result,
  input  logic             fpu_rdy,
  output logic             busy,
  output logic             fault,
  output logic [7:0]       err_cnt
);
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_result;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_err;
  logic [3:0]       r_fpu_cmd;
  logic [63:0]      r_fpu_din1;
  logic [63:0]      r_fpu_din2;
  logic             r_fpu_dval;
  logic             r_fault;
  logic [7:0]       r_err_cnt;

  logic w_legal;
  logic w_accept;
  logic w_rsp_hs;
  logic w_unused_hi;

  assign w_legal     = (req_cmd == 4'b0001) || (req_cmd == 4'b0010) || (req_cmd == 4'b0011);
  assign w_accept    = req_valid && req_ready;
  assign w_rsp_hs    = r_rsp_valid && rsp_ready;
  // Only the low word of the FPU result carries the SP value.
  assign w_unused_hi = ^fpu_result[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_err    <= 1'b0;
      r_fpu_cmd    <= '0;
      r_fpu_din1   <= '0;
      r_fpu_din2   <= '0;
      r_fpu_dval   <= 1'b0;
      r_fault      <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_fpu_dval <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rsp_tag <= req_tag;
            // Operand registers double as the FPU drive, so an illegal
            // command leaves the last issued values untouched.
            if (w_legal) begin
              r_fpu_cmd  <= req_cmd;
              r_fpu_din1 <= {32'h0, req_a};
              r_fpu_din2 <= {32'h0, req_b};
              r_fpu_dval <= 1'b1;
              r_state    <= S_ISSUE;
            end else begin
              r_rsp_result <= '0;
              r_rsp_err    <= 1'b1;
              r_rsp_valid  <= 1'b1;
              r_state      <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (fpu_rdy) begin
            r_rsp_result <= fpu_result[31:0];
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_result <= QNAN;
            r_rsp_err    <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_fault      <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
            if (r_rsp_err && (r_err_cnt != 8'hFF)) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !r_fault;
  assign busy       = (r_state != S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_err    = r_rsp_err;
  assign fpu_cmd    = r_fpu_cmd;
  assign fpu_din1   = r_fpu_din1;
  assign fpu_din2   = r_fpu_din2;
  assign fpu_dval   = r_fpu_dval;
  assign fault      = r_fault;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_fpu_sp_issuer.sv
// Bench for fpu_sp_issuer: transaction-level reference model plus a behavioural
// FPU stand-in with programmable latency, randomized traffic and directed corners.
`timescale 1ns/1ps
module tb_fpu_sp_issuer;
  localparam int         TAG_W = 4;
  localparam int         TO    = 8;
  localparam logic [3:0] C_ADD = 4'b0001;
  localparam logic [3:0] C_MUL = 4'b0010;
  localparam logic [3:0] C_DIV = 4'b0011;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_cmd = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [3:0]       fpu_cmd;
  logic [63:0]      fpu_din1;
  logic [63:0]      fpu_din2;
  logic             fpu_dval;
  logic [63:0]      fpu_result = '0;
  logic             fpu_rdy = 1'b0;
  logic             busy;
  logic             fault;
  logic [7:0]       err_cnt;

  fpu_sp_issuer #(.TAG_W(TAG_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_dval(fpu_dval),
    .fpu_result(fpu_result), .fpu_rdy(fpu_rdy),
    .busy(busy), .fault(fault), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- FPU stand-in ----------------
  int          fpu_lat = 2;   // 0 = never answers
  bit          stray   = 1'b0;
  int          f_cnt   = 0;
  logic [31:0] f_res   = '0;

  function automatic logic [31:0] fpu_calc(input logic [3:0] c, input logic [63:0] d1, input logic [63:0] d2);
    logic [31:0] a;
    logic [31:0] b;
    a = d1[31:0];
    b = d2[31:0];
    if (c == C_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (c == C_MUL && a == 32'h3F000000 && b == 32'hBEE00000) return 32'hBE600000;
    if (c == C_DIV && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return (a ^ {b[15:0], b[31:16]}) + {28'h0, c};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_rdy    = 1'b0;
      fpu_result = '0;
      f_cnt      = 0;
    end else begin
      #1;
      fpu_rdy    = 1'b0;
      fpu_result = {$urandom, $urandom};
      if (stray) begin
        fpu_rdy    = 1'b1;
        fpu_result = {$urandom, 32'hDEADBEEF};
        stray      = 1'b0;
      end else if (f_cnt > 0) begin
        f_cnt--;
        if (f_cnt == 0) begin
          fpu_rdy          = 1'b1;
          fpu_result[31:0] = f_res;
        end
      end
      if (fpu_dval) begin
        f_cnt = fpu_lat;
        f_res = fpu_calc(fpu_cmd, fpu_din1, fpu_din2);
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  bit               m_busy, m_legal, m_rv, m_fault, m_rerr, m_rdy_now;
  logic [31:0]      m_rres;
  logic [TAG_W-1:0] m_rtag;
  logic [3:0]       m_cmd;
  logic [63:0]      m_d1, m_d2;
  int               m_issue = -100;
  int               m_errs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_legal = 0; m_rv = 0; m_fault = 0; m_rerr = 0;
      m_rres = '0; m_rtag = '0; m_cmd = '0; m_d1 = '0; m_d2 = '0;
      m_issue = -100; m_errs = 0;
    end else begin
      m_rdy_now = !m_busy && !m_fault;
      if (m_busy && m_rv && rsp_ready) begin
        m_busy = 0;
        m_rv   = 0;
        if (m_rerr && m_errs < 255) m_errs++;
      end else if (m_busy && m_legal && !m_rv && cyc > m_issue) begin
        if (fpu_rdy) begin
          m_rv = 1; m_rres = fpu_result[31:0]; m_rerr = 0;
        end else if (cyc == m_issue + TO) begin
          m_rv = 1; m_rres = 32'h7FC00000; m_rerr = 1; m_fault = 1;
        end
      end
      if (m_rdy_now && req_valid) begin
        m_busy  = 1;
        m_rtag  = req_tag;
        m_legal = req_cmd inside {C_ADD, C_MUL, C_DIV};
        if (m_legal) begin
          m_cmd = req_cmd; m_d1 = {32'h0, req_a}; m_d2 = {32'h0, req_b}; m_issue = cyc + 1;
        end else begin
          m_rv = 1; m_rres = '0; m_rerr = 1;
        end
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare + observation ----------------
  int acc_cyc = 0, hs_cyc = 0, dval_cyc = 0, dval_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", req_ready, !m_busy && !m_fault);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_busy && m_rv);
      if (m_busy && m_rv) begin
        chk("rsp_result", rsp_result, m_rres);
        chk("rsp_tag", rsp_tag, m_rtag);
        chk("rsp_err", rsp_err, m_rerr);
      end
      chk("fpu_dval", fpu_dval, cyc == m_issue);
      chk("fpu_cmd", fpu_cmd, m_cmd);
      chk("fpu_din1", fpu_din1, m_d1);
      chk("fpu_din2", fpu_din2, m_d2);
      chk("fault", fault, m_fault);
      chk("err_cnt", err_cnt, m_errs[7:0]);
      if (req_valid && req_ready) acc_cyc = cyc;
      if (rsp_valid && rsp_ready) hs_cyc = cyc;
      if (fpu_dval) begin dval_cyc = cyc; dval_cnt++; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t, input bit drop);
    bit ok = 1'b0;
    req_cmd = c; req_a = a; req_b = b; req_tag = t; req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("accept_bound", ok, 1);
    @(posedge clk); #1;
    if (drop) req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int vc);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    chk("rsp_bound", ok, 1);
    vc = cyc;
  endtask

  task automatic get_rsp(input int delay, output logic [31:0] r, output logic [TAG_W-1:0] t,
                         output logic e, output int vc);
    rsp_ready = (delay == 0);
    wait_valid(vc);
    r = rsp_result; t = rsp_tag; e = rsp_err;
    if (delay > 0) begin
      repeat (delay) @(negedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_fpu_dval", fpu_dval, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_fpu_cmd", fpu_cmd, 0);
    chk("rst_fpu_din1", fpu_din1, 0);
    chk("rst_fpu_din2", fpu_din2, 0);
    chk("rst_err_cnt", err_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

  logic [31:0]      r, r2;
  logic [TAG_W-1:0] t, t2;
  logic             e, e2;
  int               vc, vc2, d0, a0, h1;
  logic [3:0]       c;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with literal expectations
    fpu_lat = 2; d0 = dval_cnt;
    send(C_ADD, 32'h3F800000, 32'h40000000, 4'h3, 1);
    a0 = acc_cyc;
    get_rsp(0, r, t, e, vc);
    chk("add_result", r, 32'h40400000);
    chk("add_tag", t, 4'h3);
    chk("add_err", e, 0);
    chk("add_latency", vc - a0, 4);
    chk("add_dval_pulses", dval_cnt - d0, 1);
    chk("add_din1", fpu_din1, 64'h0000_0000_3F80_0000);
    chk("add_err_cnt", err_cnt, 0);

    // MUL then DIV with req_valid held high
    fork
      begin
        send(C_MUL, 32'h3F000000, 32'hBEE00000, 4'h1, 0);
        send(C_DIV, 32'h40C00000, 32'h40000000, 4'h2, 1);
      end
      begin
        get_rsp(0, r, t, e, vc);
        h1 = hs_cyc;
        get_rsp(0, r2, t2, e2, vc2);
      end
    join
    chk("mul_result", r, 32'hBE600000);
    chk("mul_tag", t, 4'h1);
    chk("div_result", r2, 32'h40400000);
    chk("div_tag", t2, 4'h2);
    chk("b2b_turnaround", acc_cyc - h1, 1);

    // illegal command
    d0 = dval_cnt;
    send(4'b0101, 32'h12345678, 32'h9ABCDEF0, 4'h7, 1);
    a0 = acc_cyc;
    get_rsp(0, r, t, e, vc);
    chk("ill_latency", vc - a0, 1);
    chk("ill_result", r, 32'h0);
    chk("ill_err", e, 1);
    chk("ill_tag", t, 4'h7);
    @(negedge clk);
    chk("ill_err_cnt", err_cnt, 1);
    chk("ill_fault", fault, 0);
    chk("ill_no_dval", dval_cnt - d0, 0);
    @(posedge clk); #1;

    // backpressure with a stray rdy during the response
    fpu_lat = 3;
    send(C_ADD, 32'h3F800000, 32'h40000000, 4'hA, 1);
    rsp_ready = 1'b0;
    wait_valid(vc);
    stray = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_result", rsp_result, 32'h40400000);
      chk("bp_tag", rsp_tag, 4'hA);
      chk("bp_err", rsp_err, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
    end
    #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // randomized traffic (latency up to TO, including the rdy/timeout tie)
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) c = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(4, 15));
      else c = 4'($urandom_range(1, 3));
      fpu_lat = $urandom_range(1, TO);
      send(c, $urandom, $urandom, 4'($urandom_range(0, 15)), 1);
      get_rsp($urandom_range(0, 3), r, t, e, vc);
    end

    // asynchronous reset in the middle of WAIT
    fpu_lat = 6;
    send(C_MUL, 32'h3F000000, 32'hBEE00000, 4'h5, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fpu_lat = 2;
    send(C_ADD, 32'h3F800000, 32'h40000000, 4'h3, 1);
    get_rsp(1, r, t, e, vc);
    chk("post_rst_result", r, 32'h40400000);
    chk("post_rst_tag", t, 4'h3);
    chk("post_rst_err", e, 0);

    // error counter saturation
    for (int i = 0; i < 260; i++) begin
      send(4'($urandom_range(4, 15)), $urandom, $urandom, 4'($urandom_range(0, 15)), 1);
      get_rsp(0, r, t, e, vc);
    end
    @(negedge clk);
    chk("err_cnt_sat", err_cnt, 8'hFF);
    @(posedge clk); #1;

    // timeout: FPU never answers
    fpu_lat = 0;
    send(C_ADD, 32'h11111111, 32'h22222222, 4'h9, 1);
    get_rsp(1, r, t, e, vc);
    chk("to_latency", vc - dval_cyc, 9);
    chk("to_result", r, 32'h7FC00000);
    chk("to_err", e, 1);
    chk("to_tag", t, 4'h9);
    chk("to_fault", fault, 1);
    req_cmd = C_ADD; req_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("to_req_ready", req_ready, 0);
      chk("to_busy", busy, 0);
      chk("to_err_cnt", err_cnt, 8'hFF);
    end
    req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_sp_issuer.md
# fpu_sp_issuer

Hardware initiator for the single-precision FPU command port. It accepts one SP operation at a time over a valid/ready request channel and drives the FPU `cmd/din1/din2/dval` inputs. It waits for the FPU `rdy` pulse, or times out, and returns the result with its tag over a valid/ready response channel. It sits between a host/bus front end and `fpu_sp_top`, and replaces the directed drive sequence used in simulation with synthesizable control.

## Interface
Parameters:
- `TAG_W`, 4: width of the request/response tag.
- `TIMEOUT`, 255: maximum WAIT cycles before abort (≥2). Counter width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: high only in IDLE with `fault`=0.
- `req_cmd` in 4: `0001` ADD, `0010` MUL, `0011` DIV. Any other value is illegal.
- `req_a` in 32, `req_b` in 32: SP operands.
- `req_tag` in TAG_W: returned unchanged on the response.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_result` out 32, `rsp_tag` out TAG_W.
- `rsp_err` out 1: response is an illegal command or a timeout.
- `fpu_cmd` out 4, `fpu_din1` out 64, `fpu_din2` out 64, `fpu_dval` out 1: drive FPU inputs.
- `fpu_result` in 64, `fpu_rdy` in 1: FPU outputs. `rdy` is a one-cycle pulse, and `result[31:0]` is valid in that cycle.
- `busy` out 1: state ≠ IDLE.
- `fault` out 1: sticky timeout flag, cleared only by reset.
- `err_cnt` out 8: saturating count of error responses.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - A request is accepted when `req_valid & req_ready`, and all request fields are registered.
  - Legal cmd: go to ISSUE.
  - Illegal cmd: go directly to RESP with `rsp_result`=0 and `rsp_err`=1. The FPU is not touched.
- ISSUE (exactly 1 cycle):
  - `fpu_dval`=1.
  - `fpu_cmd` = registered cmd.
  - `fpu_din1`/`fpu_din2` = {32'h0, a}/{32'h0, b}.
  - Next state is WAIT and the wait counter is cleared to 0.
- WAIT:
  - The counter increments every cycle.
  - `fpu_rdy`=1: capture `fpu_result[31:0]` into `rsp_result`, set `rsp_err`=0, go to RESP.
  - Else, if counter == TIMEOUT−1 (i.e. TIMEOUT WAIT cycles without rdy): `rsp_result`=32'h7FC00000 (qNaN), `rsp_err`=1, `fault`←1, go to RESP.
  - If `fpu_rdy` and timeout occur in the same cycle, `rdy` wins.
- RESP:
  - `rsp_valid`=1. `rsp_result`, `rsp_tag` and `rsp_err` are held stable until `rsp_ready`=1.
  - On the handshake cycle, go to IDLE.
  - `err_cnt` increments (saturating at 255) on the handshake of any response with `rsp_err`=1.
- `fpu_rdy` is ignored in IDLE, ISSUE and RESP.
- `fpu_cmd`/`fpu_din*` hold their last issued values until the next ISSUE. `fpu_dval` is high only in ISSUE.
- With `fault`=1, `req_ready` stays 0. The block finishes the pending response and then idles permanently; the FPU is assumed wedged.
- The upper 32 bits of `fpu_result` are ignored.

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - `req_ready`=1.
  - `rsp_valid`, `rsp_err`, `fpu_dval`, `busy`, `fault` = 0.
  - `rsp_result`, `rsp_tag`, `fpu_cmd`, `fpu_din1`, `fpu_din2`, `err_cnt` = 0.
- Accept at edge N; `fpu_dval` is high in cycle N+1; WAIT starts at N+2.
- `fpu_rdy` seen in cycle M gives `rsp_valid` from cycle M+1.
- Illegal cmd accepted at N gives `rsp_valid` at N+1.
- Latency from request acceptance to `rsp_valid` is FPU latency + 2 cycles.
- After the response handshake at edge K, IDLE is entered and `req_ready`=1 in cycle K+1. There is no same-cycle turnaround.
- Only one operation is outstanding at a time, so throughput is FPU latency + 3 cycles minimum.
- Reset mid-operation (any state) returns to IDLE immediately and drops `fpu_dval`/`rsp_valid` within the same reset assertion. A partially executed FPU op is abandoned, and the FPU shares `rst_n`.

## Test plan
- ADD: `req_cmd`=0001, a=3F800000, b=40000000, tag=3 → single `fpu_dval` pulse, `fpu_din1`=0000_0000_3F80_0000; `rsp_result`=40400000, `rsp_tag`=3, `rsp_err`=0, `err_cnt`=0.
- MUL then DIV back-to-back with `req_valid` held high:
  - 3F000000×BEE00000 → BE600000.
  - 40C00000÷40000000 → 40400000.
  - Second acceptance occurs exactly 1 cycle after the first response handshake.
- Illegal cmd 0101, tag=7 → `rsp_valid` on the next cycle, `rsp_result`=0, `rsp_err`=1, `fpu_dval` never asserted, `err_cnt`=1, `fault`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid`, and inject a stray `fpu_rdy` with `fpu_result`=DEADBEEF in RESP → response stays unchanged, `req_ready`=0 throughout.
- Timeout with TIMEOUT=8 and an FPU model that never asserts `rdy` → `rsp_valid` 9 cycles after the ISSUE cycle, `rsp_result`=7FC00000, `rsp_err`=1, `fault`=1; after the handshake `req_ready` stays 0.
- Reset mid-WAIT (assert `rst_n`=0 asynchronously between edges) → all outputs return to reset values without a clock edge; after release, an ADD request completes normally.
